// File: rtl/ysyx_24090003_lsu_pkg.sv
// Shared encodings for the LSU: memory-op codes, FSM states, exception codes
// and small op-classification helpers.
package ysyx_24090003_lsu_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_OUT  = 2'd3
    } lsu_state_e;

    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_BUS      = 2'd2;
    localparam logic [1:0] EXC_TIMEOUT  = 2'd3;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_mem(input logic [3:0] op);
        return op_is_load(op) || op_is_store(op);
    endfunction

    // Byte ops can never be misaligned; codes 9..15 behave like NONE.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lane);
        logic w_half;
        logic w_word;
        w_half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        w_word = (op == OP_LW) || (op == OP_SW);
        return (w_half && lane[0]) || (w_word && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_24090003_lsu_align.sv
// Combinational lane logic: load extraction from the read word and store
// data replication / byte-strobe generation.
module ysyx_24090003_lsu_align
    import ysyx_24090003_lsu_pkg::*;
(
    input  logic [3:0]  i_mem_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    assign w_half = i_rdata[{i_lane[1], 4'b0000} +: 16];

    always_comb begin
        o_load_data = 32'd0;
        o_wdata     = 32'd0;
        o_wstrb     = 4'd0;
        case (i_mem_op)
            OP_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU: o_load_data = {24'd0, w_byte};
            OP_LH:  o_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU: o_load_data = {16'd0, w_half};
            OP_LW:  o_load_data = i_rdata;
            OP_SB: begin
                o_wdata = {4{i_store_data[7:0]}};
                o_wstrb = 4'b0001 << i_lane;
            end
            OP_SH: begin
                o_wdata = {2{i_store_data[15:0]}};
                o_wstrb = 4'b0011 << {i_lane[1], 1'b0};
            end
            OP_SW: begin
                o_wdata = i_store_data;
                o_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_24090003_lsu.sv
// Load/store unit: one transaction in flight, request/grant memory port,
// bounded wait with timeout, registered writeback handshake.
//   state | meaning
//   IDLE  | o_ready high, waiting for an instruction
//   REQ   | o_mem_req high, waiting for grant
//   RSP   | granted, waiting for rvalid
//   OUT   | result presented on o_valid until i_ready
module ysyx_24090003_lsu
    import ysyx_24090003_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_store_data,
    input  logic [3:0]  i_mem_op,
    input  logic [4:0]  i_rd,
    input  logic        i_rd_wen,
    output logic        o_mem_req,
    input  logic        i_mem_gnt,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_err,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_rd,
    output logic        o_rd_wen,
    output logic        o_exc,
    output logic [1:0]  o_exc_code
);

    lsu_state_e  r_state;
    logic [3:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [4:0]  r_rd;
    logic        r_rd_wen;
    logic [15:0] r_cnt;
    logic        r_ready;
    logic        r_mem_req;
    logic        r_valid;
    logic [31:0] r_wb_data;
    logic        r_rd_wen_out;
    logic        r_exc;
    logic [1:0]  r_exc_code;

    logic [31:0] w_load_data;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [16:0] w_cnt_nxt;
    logic        w_timeout;
    logic        w_rsp_hit;
    logic        w_store;
    logic [31:0] w_rsp_wb;
    logic        w_rsp_wen;

    ysyx_24090003_lsu_align u_align (
        .i_mem_op     (r_op),
        .i_lane       (r_addr[1:0]),
        .i_store_data (r_sdata),
        .i_rdata      (i_mem_rdata),
        .o_load_data  (w_load_data),
        .o_wdata      (w_wdata),
        .o_wstrb      (w_wstrb)
    );

    assign w_cnt_nxt = {1'b0, r_cnt} + 17'd1;
    assign w_timeout = (w_cnt_nxt == 17'(TIMEOUT_CYC));
    // A response counts in REQ only together with the grant.
    assign w_rsp_hit = i_mem_rvalid && ((r_state == ST_RSP) || ((r_state == ST_REQ) && i_mem_gnt));
    assign w_store   = op_is_store(r_op);
    assign w_rsp_wb  = (i_mem_err || w_store) ? 32'd0 : w_load_data;
    assign w_rsp_wen = !i_mem_err && !w_store && r_rd_wen;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_NONE;
            r_addr       <= 32'd0;
            r_sdata      <= 32'd0;
            r_rd         <= 5'd0;
            r_rd_wen     <= 1'b0;
            r_cnt        <= 16'd0;
            r_ready      <= 1'b0;
            r_mem_req    <= 1'b0;
            r_valid      <= 1'b0;
            r_wb_data    <= 32'd0;
            r_rd_wen_out <= 1'b0;
            r_exc        <= 1'b0;
            r_exc_code   <= EXC_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (i_valid && r_ready) begin
                        r_ready  <= 1'b0;
                        r_op     <= i_mem_op;
                        r_addr   <= i_alu_result;
                        r_sdata  <= i_store_data;
                        r_rd     <= i_rd;
                        r_rd_wen <= i_rd_wen;
                        if (!op_is_mem(i_mem_op)) begin
                            r_state      <= ST_OUT;
                            r_valid      <= 1'b1;
                            r_wb_data    <= i_alu_result;
                            r_rd_wen_out <= i_rd_wen;
                            r_exc        <= 1'b0;
                            r_exc_code   <= EXC_NONE;
                        end else if (op_misaligned(i_mem_op, i_alu_result[1:0])) begin
                            r_state      <= ST_OUT;
                            r_valid      <= 1'b1;
                            r_wb_data    <= 32'd0;
                            r_rd_wen_out <= 1'b0;
                            r_exc        <= 1'b1;
                            r_exc_code   <= EXC_MISALIGN;
                        end else begin
                            r_state   <= ST_REQ;
                            r_mem_req <= 1'b1;
                            r_cnt     <= 16'd0;
                        end
                    end
                end
                ST_REQ, ST_RSP: begin
                    r_cnt <= w_cnt_nxt[15:0];
                    if (w_rsp_hit) begin
                        r_state      <= ST_OUT;
                        r_mem_req    <= 1'b0;
                        r_valid      <= 1'b1;
                        r_wb_data    <= w_rsp_wb;
                        r_rd_wen_out <= w_rsp_wen;
                        r_exc        <= i_mem_err;
                        r_exc_code   <= i_mem_err ? EXC_BUS : EXC_NONE;
                    end else if (w_timeout) begin
                        r_state      <= ST_OUT;
                        r_mem_req    <= 1'b0;
                        r_valid      <= 1'b1;
                        r_wb_data    <= 32'd0;
                        r_rd_wen_out <= 1'b0;
                        r_exc        <= 1'b1;
                        r_exc_code   <= EXC_TIMEOUT;
                    end else if ((r_state == ST_REQ) && i_mem_gnt) begin
                        r_state   <= ST_RSP;
                        r_mem_req <= 1'b0;
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready     = r_ready;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = w_store;
    assign o_mem_addr  = {r_addr[31:2], 2'b00};
    assign o_mem_wdata = w_wdata;
    assign o_mem_wstrb = w_wstrb;
    assign o_valid     = r_valid;
    assign o_wb_data   = r_wb_data;
    assign o_rd        = r_rd;
    assign o_rd_wen    = r_rd_wen_out;
    assign o_exc       = r_exc;
    assign o_exc_code  = r_exc_code;

endmodule
